// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin time-sharing of one combinational ALU between NREQ requesters
// Each op is registered, presented to the ALU for one EXEC cycle, then returned to its issuer in RESP.
module alu_share_arb #(
    parameter int NREQ = 2,
    parameter int ARCH = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_in,
    output logic [NREQ-1:0]      req_ready_out,
    input  logic [NREQ*4-1:0]    req_ctrl_in,
    input  logic [NREQ*ARCH-1:0] req_a_in,
    input  logic [NREQ*ARCH-1:0] req_b_in,
    output logic [NREQ-1:0]      rsp_valid_out,
    input  logic [NREQ-1:0]      rsp_ready_in,
    output logic [ARCH-1:0]      rsp_result_out,
    output logic                 rsp_zero_out,
    output logic                 busy_out,
    output logic [3:0]           alu_ctrl_out,
    output logic [ARCH-1:0]      alu_a_out,
    output logic [ARCH-1:0]      alu_b_out,
    input  logic [ARCH-1:0]      alu_result_in,
    input  logic                 alu_zero_in
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_owner;
    logic [3:0]      r_ctrl;
    logic [ARCH-1:0] r_a;
    logic [ARCH-1:0] r_b;
    logic [ARCH-1:0] r_result;
    logic            r_zero;

    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_accept;

    // Scan from the highest offset down so the offset closest to r_rr_ptr wins.
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (req_valid_in[IDW'(w_idx)]) begin
                w_found = 1'b1;
                w_grant = IDW'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (int'(w_grant) == NREQ - 1) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        req_ready_out = '0;
        rsp_valid_out = '0;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so nothing is offered while reset is held.
                if (w_found && rst_n) begin
                    req_ready_out[w_grant] = 1'b1;
                    w_accept               = 1'b1;
                    w_state_nxt            = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid_out[r_owner] = 1'b1;
                if (rsp_ready_in[r_owner]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ctrl   <= req_ctrl_in[4*int'(w_grant) +: 4];
                r_a      <= req_a_in[ARCH*int'(w_grant) +: ARCH];
                r_b      <= req_b_in[ARCH*int'(w_grant) +: ARCH];
                r_owner  <= w_grant;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_EXEC) begin
                r_result <= alu_result_in;
                r_zero   <= alu_zero_in;
            end
        end
    end

    assign busy_out       = (r_state != S_IDLE);
    assign alu_ctrl_out   = r_ctrl;
    assign alu_a_out      = r_a;
    assign alu_b_out      = r_b;
    assign rsp_result_out = r_result;
    assign rsp_zero_out   = r_zero;

endmodule
